// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial A - B - Bin, LSB first, start/done handshake (optional ovf output: SERIAL_SUB_OVF_EN)
module serial_subtractor #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
`ifdef SERIAL_SUB_OVF_EN
    output logic             Bout,
    output logic             ovf
`else
    output logic             Bout
`endif
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             br_q, br_d;
    logic             bout_q, bout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    // Single full-subtractor cell operating on the current LSBs.
    logic             a_bit, b_bit, d_bit, br_next, last_bit;
    logic [WIDTH-1:0] diff_sh;

    assign a_bit    = a_sr_q[0];
    assign b_bit    = b_sr_q[0];
    assign d_bit    = a_bit ^ b_bit ^ br_q;
    assign br_next  = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_q);
    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));
    assign diff_sh  = WIDTH'({d_bit, diff_q} >> 1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        diff_d  = diff_q;
        d_d     = d_q;
        br_d    = br_q;
        bout_d  = bout_q;
        done_d  = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    a_sr_d  = A;
                    b_sr_d  = B;
                    br_d    = Bin;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                a_sr_d = a_sr_q >> 1;
                b_sr_d = b_sr_q >> 1;
                diff_d = diff_sh;
                br_d   = br_next;
                cnt_d  = cnt_q + CNT_W'(1);
                if (last_bit) begin
                    state_d = IDLE;
                    d_d     = diff_sh;
                    bout_d  = br_next;
                    done_d  = 1'b1;
`ifdef SERIAL_SUB_OVF_EN
                    // Signed overflow: borrow into the MSB cell differs from borrow out.
                    ovf_d   = br_q ^ br_next;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == RUN);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            diff_q  <= '0;
            d_q     <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            diff_q  <= diff_d;
            d_q     <= d_d;
            br_q    <= br_d;
            bout_q  <= bout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign D    = d_q;
    assign Bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule
